screen_pf_fetch: RTL

Streaming pixel/character fetch engine for the screen path. It sits between the screen timing/render logic and the shared memory port. On a start pulse it reads a run of consecutive `DW`-bit words from memory through a `DEPTH`-word prefetch FIFO, then delivers them to the renderer one byte at a time on demand. This is the parametrised successor of the fixed text-mode pattern source: it implements real memory fetch with credit-based flow control, and keeps the test pattern as a compile option.

---
 rtl/screen_pf_fetch.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/screen_pf_fetch.sv
// -----------------------------------------------------------------------------
// screen_pf_fetch
//
// Streaming fetch engine for the screen path. A start pulse latches a base word
// address and a word count; the engine then reads that many consecutive DW-bit
// words from the shared memory port into a DEPTH-word prefetch FIFO, and hands
// them to the renderer one byte at a time (least-significant byte first).
// Address requests are credit-limited so the FIFO can never overflow: a request
// is only issued while (outstanding reads + words held) < DEPTH.
//
// Build option:
//   SCREEN_PF_TESTPAT_EN  - when defined, the memory port is disabled and an
//                           internal generator fills the FIFO with the
//                           printable-ASCII test text (byte i = i+32 for i<95,
//                           else blank 0x20). pf_base is ignored.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   pf_start             start pulse (honoured only when idle and pf_len != 0)
//   pf_base [AW]         first word address, latched on start
//   pf_len  [LW]         number of words to fetch, latched on start
//   pf_busy              transfer in progress (FETCH or DRAIN)
//   pf_rd                consume the current byte
//   pf_dat  [8]          current byte (0x20 when nothing is available)
//   pf_dat_vld           pf_dat holds a real byte
//   mem_addr_vld/_gnt    read-address request / accept handshake
//   mem_addr [AW]        read word address
//   mem_dat_vld/_gnt     read-data valid / accept handshake
//   mem_dat  [DW]        read data
// -----------------------------------------------------------------------------
module screen_pf_fetch #(
  parameter int AW    = 19,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int LW    = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pf_start,
  input  logic [AW-1:0] pf_base,
  input  logic [LW-1:0] pf_len,
  output logic          pf_busy,
  input  logic          pf_rd,
  output logic [7:0]    pf_dat,
  output logic          pf_dat_vld,
  output logic          mem_addr_vld,
  input  logic          mem_addr_gnt,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_dat_vld,
  output logic          mem_dat_gnt,
  input  logic [DW-1:0] mem_dat
);

  localparam int NB  = DW / 8;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int LNW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LNW-1:0] LANE_LAST = LNW'(NB - 1);
  localparam logic [CW:0]    CREDITS   = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [LW-1:0]  req_left_r;
  logic [CW-1:0]  outst_r;
  logic [CW-1:0]  fifo_cnt_r;
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [DW-1:0]  fifo_mem_r [DEPTH];
  logic [LNW-1:0] lane_r;
  logic           err_unexp_r;

  logic          start_s;
  logic          credit_ok_s;
  logic          issue_s;
  logic          grant_s;
  logic          push_s;
  logic          unexp_s;
  logic          out_inc_s;
  logic          out_dec_s;
  logic          rd_ok_s;
  logic          pop_s;
  logic [DW-1:0] push_dat_s;
  logic [DW-1:0] head_s;

  assign start_s = (state_r == ST_IDLE) && pf_start && (pf_len != {LW{1'b0}});

  // Registered counts only: a word popped this cycle frees its credit next cycle.
  assign credit_ok_s = ({1'b0, outst_r} + {1'b0, fifo_cnt_r}) < CREDITS;
  assign issue_s     = (state_r == ST_FETCH) && (req_left_r != {LW{1'b0}}) && credit_ok_s;

`ifdef SCREEN_PF_TESTPAT_EN
  logic [LW-1:0] gen_k_r;
  logic          unused_sink_s;

  // Word k of the ASCII test text; byte n carries transfer byte k*NB+n.
  function automatic logic [DW-1:0] pat_word(input logic [LW-1:0] k);
    logic [DW-1:0] w;
    int unsigned   idx;
    w = {DW{1'b0}};
    for (int n = 0; n < NB; n++) begin
      idx = 32'(k) * 32'(NB) + 32'(n);
      w[8*n +: 8] = (idx < 32'd95) ? 8'(idx + 32'd32) : 8'h20;
    end
    return w;
  endfunction

  // The generator produces a word whenever a credit is available, straight into the FIFO.
  assign grant_s       = issue_s;
  assign push_s        = grant_s;
  assign unexp_s       = 1'b0;
  assign out_inc_s     = 1'b0;
  assign out_dec_s     = 1'b0;
  assign push_dat_s    = pat_word(gen_k_r);
  assign mem_addr_vld  = 1'b0;
  assign mem_addr      = {AW{1'b0}};
  assign mem_dat_gnt   = 1'b1;
  assign unused_sink_s = ^{pf_base, mem_addr_gnt, mem_dat_vld, mem_dat, err_unexp_r};

  // Word index within the current transfer for the pattern generator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_k_r <= {LW{1'b0}};
    end else if (start_s) begin
      gen_k_r <= {LW{1'b0}};
    end else if (grant_s) begin
      gen_k_r <= gen_k_r + LW'(1);
    end
  end
`else
  logic [AW-1:0] addr_r;
  logic          acc_s;
  logic          unused_sink_s;

  assign grant_s      = issue_s & mem_addr_gnt;
  assign acc_s        = mem_dat_vld & pf_busy;
  // Data with no read in flight is swallowed and flagged, never delivered.
  assign push_s       = acc_s & (outst_r != {CW{1'b0}});
  assign unexp_s      = acc_s & (outst_r == {CW{1'b0}});
  assign out_inc_s    = grant_s;
  assign out_dec_s    = push_s;
  assign push_dat_s   = mem_dat;
  assign mem_addr_vld = issue_s;
  assign mem_addr     = addr_r;
  assign mem_dat_gnt  = pf_busy;
  // err_unexp has no port; it is kept for debug observation.
  assign unused_sink_s = err_unexp_r;

  // Read word address: latched on start, stepped on each accepted request (wraps).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r <= {AW{1'b0}};
    end else if (start_s) begin
      addr_r <= pf_base;
    end else if (grant_s) begin
      addr_r <= addr_r + AW'(1);
    end
  end
`endif

  assign pf_busy    = (state_r != ST_IDLE);
  assign pf_dat_vld = (fifo_cnt_r != {CW{1'b0}});
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign rd_ok_s    = pf_rd & pf_dat_vld;
  assign pop_s      = rd_ok_s & (lane_r == LANE_LAST);

  // Byte select from the FIFO head; blank when nothing is available.
  always_comb begin
    pf_dat = 8'h20;
    if (pf_dat_vld) begin
      pf_dat = 8'(head_s >> {lane_r, 3'b000});
    end else begin
      pf_dat = 8'h20;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_FETCH;
        else         state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (grant_s && (req_left_r == LW'(1))) state_s = ST_DRAIN;
        else                                   state_s = ST_FETCH;
      end
      ST_DRAIN: begin
        if ((outst_r == {CW{1'b0}}) && (fifo_cnt_r == {CW{1'b0}})) state_s = ST_IDLE;
        else                                                       state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Words still to request in this transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_left_r <= {LW{1'b0}};
    end else if (start_s) begin
      req_left_r <= pf_len;
    end else if (grant_s) begin
      req_left_r <= req_left_r - LW'(1);
    end
  end

  // Reads in flight; a same-cycle request and return cancel out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_r <= {CW{1'b0}};
    end else begin
      case ({out_inc_s, out_dec_s})
        2'b10:   outst_r <= outst_r + CW'(1);
        2'b01:   outst_r <= outst_r - CW'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

  // FIFO occupancy and pointers; a same-cycle push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_cnt_r <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // FIFO storage (no reset needed: occupancy gates every read).
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= push_dat_s;
  end

  // Byte lane within the head word; wrapping past the last lane pops the word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_r <= {LNW{1'b0}};
    end else if (rd_ok_s) begin
      if (lane_r == LANE_LAST) lane_r <= {LNW{1'b0}};
      else                     lane_r <= lane_r + LNW'(1);
    end
  end

  // Sticky flag for data returned with no read in flight; cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        err_unexp_r <= 1'b0;
    else if (unexp_s) err_unexp_r <= 1'b1;
  end

endmodule
